// File: rtl/timer_wavegen.sv
// Waveform/interrupt stage behind the 8-bit timer: turns match and wrap events
// into toggle or PWM outputs, keeps W1C event flags and drives a level irq.
module timer_wavegen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    input  logic [7:0] counter,
    input  logic       match0,
    input  logic       match1,
    output logic       wave0,
    output logic       wave1,
    output logic       irq
);
    localparam logic [7:0] ADDR_CTRL  = 8'h10;
    localparam logic [7:0] ADDR_FLAGS = 8'h11;
    localparam logic [7:0] ADDR_FORCE = 8'h12;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_TOGGLE  = 2'b01,
        MODE_PWM     = 2'b10,
        MODE_PWM_INV = 2'b11
    } mode_e;

    logic [7:0] ctrl_q, ctrl_d;
    logic [2:0] flags_q, flags_d;        // {wf, mf1, mf0}
    logic       ie2_q, ie2_d;
    logic [1:0] s_q, s_d;
    logic [1:0] match_prev_q, match_prev_d;
    logic [7:0] counter_prev_q, counter_prev_d;
    logic [7:0] dout_q, dout_d;
    logic       irq_q, irq_d;

    logic [1:0] mev;
    logic       wev;
    logic       wr_ctrl, wr_flags, wr_force;
    logic [1:0] frc;
    mode_e      mode [2];

    always_comb begin
        mev            = {match1, match0} & ~match_prev_q;
        wev            = (counter == 8'd0) && (counter_prev_q != 8'd0);
        wr_ctrl        = w_en && (address == ADDR_CTRL);
        wr_flags       = w_en && (address == ADDR_FLAGS);
        wr_force       = w_en && (address == ADDR_FORCE);
        frc            = wr_force ? din[1:0] : 2'b00;
        mode[0]        = mode_e'(ctrl_q[1:0]);
        mode[1]        = mode_e'(ctrl_q[3:2]);
        match_prev_d   = {match1, match0};
        counter_prev_d = counter;
        ctrl_d         = wr_ctrl ? din : ctrl_q;
        ie2_d          = wr_flags ? din[3] : ie2_q;
        // Event sets take priority over a coincident write-1-to-clear.
        flags_d        = (flags_q & ~(wr_flags ? din[2:0] : 3'b000)) | {wev, mev};
        irq_d          = |(flags_q[1:0] & ctrl_q[5:4]) | (flags_q[2] & ie2_q);

        // Channel state runs off the current mode; a new mode applies next cycle.
        s_d = s_q;
        for (int i = 0; i < 2; i++) begin
            if (mode[i] == MODE_OFF) begin
                s_d[i] = 1'b0;
            end else if (frc[i]) begin
                s_d[i] = ~s_q[i];
            end else begin
                case (mode[i])
                    MODE_TOGGLE:  if (mev[i]) s_d[i] = ~s_q[i];
                    MODE_PWM:     if (mev[i]) s_d[i] = 1'b0; else if (wev) s_d[i] = 1'b1;
                    MODE_PWM_INV: if (mev[i]) s_d[i] = 1'b1; else if (wev) s_d[i] = 1'b0;
                    default:      s_d[i] = 1'b0;
                endcase
            end
        end

        dout_d = dout_q;
        if (r_en) begin
            case (address)
                ADDR_CTRL:  dout_d = ctrl_q;
                ADDR_FLAGS: dout_d = {4'b0000, ie2_q, flags_q};
                ADDR_FORCE: dout_d = 8'h00;
                default:    dout_d = dout_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q         <= 8'h00;
            flags_q        <= 3'b000;
            ie2_q          <= 1'b0;
            s_q            <= 2'b00;
            match_prev_q   <= 2'b00;
            counter_prev_q <= 8'h00;
            dout_q         <= 8'h00;
            irq_q          <= 1'b0;
        end else begin
            ctrl_q         <= ctrl_d;
            flags_q        <= flags_d;
            ie2_q          <= ie2_d;
            s_q            <= s_d;
            match_prev_q   <= match_prev_d;
            counter_prev_q <= counter_prev_d;
            dout_q         <= dout_d;
            irq_q          <= irq_d;
        end
    end

    assign wave0 = s_q[0] & ctrl_q[6];
    assign wave1 = s_q[1] & ctrl_q[7];
    assign irq   = irq_q;
    assign dout  = dout_q;
endmodule

// File: tb/tb_timer_wavegen.sv
// Bench for timer_wavegen: a cycle table, hand-built corner sequences and a
// randomized run against an event-rule reference model.
module tb_timer_wavegen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00, address = 8'h00, counter = 8'h00;
    logic       w_en = 1'b0, r_en = 1'b0, match0 = 1'b0, match1 = 1'b0;
    logic [7:0] dout;
    logic       wave0, wave1, irq;

    int n_cmp = 0;
    int n_bad = 0;

    timer_wavegen dut (
        .clk(clk), .rst_n(rst_n), .din(din), .address(address), .w_en(w_en),
        .r_en(r_en), .dout(dout), .counter(counter), .match0(match0),
        .match1(match1), .wave0(wave0), .wave1(wave1), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model state: register images plus previous sampled inputs.
    logic [7:0] m_ctrl, m_dout, m_pc;
    logic       m_mf [2];
    logic       m_s  [2];
    logic       m_pm [2];
    logic       m_wf, m_ie2, m_irq;

    task automatic model_reset();
        m_ctrl = 0; m_dout = 0; m_pc = 0; m_wf = 0; m_ie2 = 0; m_irq = 0;
        for (int c = 0; c < 2; c++) begin
            m_mf[c] = 0; m_s[c] = 0; m_pm[c] = 0;
        end
    endtask

    task automatic model_step();
        logic       ev [2];
        logic       wrap;
        logic [1:0] md;
        ev[0] = match0 && !m_pm[0];
        ev[1] = match1 && !m_pm[1];
        wrap  = (counter == 0) && (m_pc != 0);
        m_irq = (m_mf[0] && m_ctrl[4]) || (m_mf[1] && m_ctrl[5]) || (m_wf && m_ie2);
        if (r_en) begin
            if (address == 8'h10)      m_dout = m_ctrl;
            else if (address == 8'h11) m_dout = {4'd0, m_ie2, m_wf, m_mf[1], m_mf[0]};
            else if (address == 8'h12) m_dout = 8'h00;
        end
        for (int c = 0; c < 2; c++) begin
            md = m_ctrl[2*c +: 2];
            if (md == 2'd0)                                m_s[c] = 0;
            else if (w_en && address == 8'h12 && din[c])   m_s[c] = !m_s[c];
            else if (ev[c])                                m_s[c] = (md == 2'd1) ? !m_s[c] : (md == 2'd3);
            else if (wrap && md != 2'd1)                   m_s[c] = (md == 2'd2);
        end
        if (w_en && address == 8'h11) begin
            if (din[0]) m_mf[0] = 0;
            if (din[1]) m_mf[1] = 0;
            if (din[2]) m_wf = 0;
            m_ie2 = din[3];
        end
        if (ev[0]) m_mf[0] = 1;
        if (ev[1]) m_mf[1] = 1;
        if (wrap)  m_wf = 1;
        if (w_en && address == 8'h10) m_ctrl = din;
        m_pm[0] = match0; m_pm[1] = match1; m_pc = counter;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic m0_at_release);
        rst_n = 0; w_en = 0; r_en = 0; match0 = 0; match1 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        match0 = m0_at_release;
        rst_n = 1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        w_en = 1; address = a; din = d;
        tick();
        w_en = 0;
    endtask

    task automatic rd(input logic [7:0] a);
        r_en = 1; address = a;
        tick();
        r_en = 0;
    endtask

    typedef struct {
        logic       we, re;
        logic [7:0] addr, data;
        logic       m0;
        logic       w0, irq;
        logic [7:0] dout;
    } vec_t;
    vec_t tbl [12];

    int hi;
    int lvl;
    logic [7:0] cmp0, cmp1, top;

    initial begin
        tbl[0]  = '{1, 0, 8'h10, 8'h51, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h00};
        tbl[2]  = '{0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h00};
        tbl[3]  = '{0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h00};
        tbl[4]  = '{0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h00};
        tbl[5]  = '{0, 1, 8'h11, 8'h00, 0, 0, 1, 8'h01};
        tbl[6]  = '{1, 0, 8'h11, 8'h01, 1, 1, 1, 8'h01};
        tbl[7]  = '{1, 0, 8'h11, 8'h01, 0, 1, 1, 8'h01};
        tbl[8]  = '{0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h01};
        tbl[9]  = '{1, 1, 8'h10, 8'h00, 0, 0, 0, 8'h51};
        tbl[10] = '{0, 1, 8'h13, 8'h00, 0, 0, 0, 8'h51};
        tbl[11] = '{0, 1, 8'h12, 8'h00, 0, 0, 0, 8'h00};

        // Reset state and the cycle table
        counter = 8'd5;
        do_reset(0);
        chk("rst_wave0", {7'd0, wave0}, 0);
        chk("rst_irq",   {7'd0, irq}, 0);
        chk("rst_dout",  dout, 8'h00);
        for (int i = 0; i < 12; i++) begin
            w_en = tbl[i].we; r_en = tbl[i].re; address = tbl[i].addr;
            din = tbl[i].data; match0 = tbl[i].m0;
            tick();
            chk($sformatf("tbl%0d_wave0", i), {7'd0, wave0}, {7'd0, tbl[i].w0});
            chk($sformatf("tbl%0d_irq", i),   {7'd0, irq},   {7'd0, tbl[i].irq});
            chk($sformatf("tbl%0d_dout", i),  dout,          tbl[i].dout);
        end
        w_en = 0; r_en = 0; match0 = 0;

        // Toggle: three 3-cycle pulses, one toggle per rising edge
        wr(8'h10, 8'h41);
        lvl = 0;
        for (int p = 0; p < 3; p++) begin
            match0 = 1;
            lvl = 1 - lvl;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk($sformatf("tog_p%0d_hi%0d", p, k), {7'd0, wave0}, lvl[7:0]);
            end
            match0 = 0;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk($sformatf("tog_p%0d_lo%0d", p, k), {7'd0, wave0}, lvl[7:0]);
            end
        end
        rd(8'h11);
        chk("tog_mf0", dout & 8'h01, 8'h01);

        // PWM: match at 64 gives 64 high cycles per 256
        do_reset(0);
        counter = 8'd255;
        wr(8'h10, 8'h42);
        for (int p = 0; p < 2; p++) begin
            hi = 0;
            for (int c = 0; c < 256; c++) begin
                counter = c[7:0]; match0 = (c == 64);
                tick();
                hi += wave0;
            end
        end
        chk("pwm_duty64", hi[7:0], 8'd64);
        match0 = 0;
        for (int c = 0; c < 3; c++) begin
            counter = c[7:0];
            tick();
        end
        chk("pwm_high_after_wrap", {7'd0, wave0}, 1);

        // match at counter 0: mode 10 stays low, mode 11 stays high
        counter = 8'd255; match0 = 0;
        wr(8'h10, 8'h42);
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            counter = c[7:0]; match0 = (c == 0);
            tick();
            hi += wave0;
        end
        chk("pwm_cmp0_low", hi[7:0], 8'd0);
        counter = 8'd255; match0 = 0;
        wr(8'h10, 8'h43);
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            counter = c[7:0]; match0 = (c == 0);
            tick();
            hi += wave0;
        end
        chk("pwm_inv_cmp0_high", hi[8:1], 8'd128);

        // Force with OE off, then enable OE
        do_reset(0);
        wr(8'h10, 8'h01);
        wr(8'h12, 8'h01);
        chk("force_oe_off", {7'd0, wave0}, 0);
        wr(8'h10, 8'h41);
        chk("force_oe_on", {7'd0, wave0}, 1);
        wr(8'h12, 8'h01);
        chk("force_back", {7'd0, wave0}, 0);

        // Asynchronous reset mid-run
        do_reset(0);
        wr(8'h10, 8'h51);
        match0 = 1; tick(); match0 = 0;
        rd(8'h10);
        chk("pre_rst_wave0", {7'd0, wave0}, 1);
        chk("pre_rst_irq",   {7'd0, irq}, 1);
        chk("pre_rst_dout",  dout, 8'h51);
        #3 rst_n = 0;
        model_reset();
        #1;
        chk("async_wave0", {7'd0, wave0}, 0);
        chk("async_irq",   {7'd0, irq}, 0);
        chk("async_dout",  dout, 8'h00);
        @(posedge clk); #1;
        rst_n = 1;
        rd(8'h10);
        chk("post_rst_ctrl", dout, 8'h00);
        rd(8'h11);
        chk("post_rst_flags", dout, 8'h00);
        do_reset(1);
        tick();
        rd(8'h11);
        chk("release_match_edge", dout, 8'h01);

        // Randomized run against the reference model
        do_reset(0);
        counter = 0; top = 8'd40; cmp0 = 8'd10; cmp1 = 8'd25;
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) begin
                top  = 8'($urandom_range(8, 80));
                cmp0 = 8'($urandom_range(0, 80));
                cmp1 = 8'($urandom_range(0, 80));
            end
            counter = ($urandom % 64 == 0) ? 8'($urandom) : ((counter >= top) ? 8'd0 : counter + 8'd1);
            match0  = (counter == cmp0) || ($urandom % 32 == 0);
            match1  = (counter == cmp1) || ($urandom % 32 == 0);
            w_en    = ($urandom % 10 == 0);
            r_en    = ($urandom % 6 == 0);
            address = 8'h10 + 8'($urandom % 4);
            din     = 8'($urandom);
            if (w_en && address == 8'h10 && ($urandom % 4 != 0)) din[7:4] = 4'hF;
            tick();
            chk("rnd_wave0", {7'd0, wave0}, {7'd0, m_s[0] & m_ctrl[6]});
            chk("rnd_wave1", {7'd0, wave1}, {7'd0, m_s[1] & m_ctrl[7]});
            chk("rnd_irq",   {7'd0, irq},   {7'd0, m_irq});
            chk("rnd_dout",  dout, m_dout);
        end
        w_en = 0; r_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
